// File: rtl/dinorun_pkg.sv
// Shared display types for the dinorun game: seven-segment glyph type,
// hex glyph table (active-high, bit 0 = segment a) and the all-off pattern.
package dinorun_pkg;

  typedef logic [6:0] seg7_t;

  // Index 0..15 -> 0-9, A, b, C, d, E, F
  localparam seg7_t SEG7_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam seg7_t SEG7_OFF = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-high seven-segment glyph.
module seg7_decode
  import dinorun_pkg::*;
(
  input  logic [3:0] value,
  output seg7_t      seg
);

  assign seg = SEG7_GLYPH[value];

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with frame-coherent snapshot.
// Optional leading-zero blanking enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan
  import dinorun_pkg::*;
#(
  parameter int REFRESH_DIV  = 6294,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] digit0_i,
  input  logic [3:0] digit1_i,
  input  logic [3:0] digit2_i,
  input  logic [3:0] digit3_i,
  input  logic       digit0_en_i,
  input  logic       digit1_en_i,
  input  logic       digit2_en_i,
  input  logic       digit3_en_i,
  output logic [3:0] an_no,
  output logic [6:0] seg_no,
  output logic       dp_no
);

  logic [15:0] div_q;
  logic [1:0]  slot_q;
  logic [3:0]  snap_val [4];
  logic [3:0]  snap_en;
  logic [3:0]  blank;
  logic [3:0]  cur_val;
  logic        snap_now;
  logic        visible;
  seg7_t       glyph;

  assign snap_now = (div_q == 16'd0) && (slot_q == 2'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      slot_q <= '0;
    end else if (div_q == 16'(REFRESH_DIV - 1)) begin
      div_q  <= '0;
      slot_q <= slot_q + 2'd1;
    end else begin
      div_q  <= div_q + 16'd1;
    end
  end

  // Inputs are sampled once per frame so a score change never shows mixed digits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) snap_val[i] <= '0;
      snap_en <= '0;
    end else if (snap_now) begin
      snap_val[0] <= digit0_i;
      snap_val[1] <= digit1_i;
      snap_val[2] <= digit2_i;
      snap_val[3] <= digit3_i;
      snap_en     <= {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i};
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A disabled digit counts as a leading zero; digit0 always stays lit
  always_comb begin
    blank    = '0;
    blank[3] = !snap_en[3] || (snap_val[3] == 4'd0);
    blank[2] = blank[3] && (!snap_en[2] || (snap_val[2] == 4'd0));
    blank[1] = blank[2] && (!snap_en[1] || (snap_val[1] == 4'd0));
  end
`else
  assign blank = '0;
`endif

  assign cur_val = snap_val[slot_q];
  assign visible = snap_en[slot_q] && (div_q >= 16'(BLANK_CYCLES)) && !blank[slot_q];

  seg7_decode u_decode (
    .value (cur_val),
    .seg   (glyph)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_no  <= 4'b1111;
      seg_no <= SEG7_OFF;
    end else if (visible) begin
      an_no  <= ~(4'b0001 << slot_q);
      seg_no <= ~glyph;
    end else begin
      an_no  <= 4'b1111;
      seg_no <= SEG7_OFF;
    end
  end

  assign dp_no = 1'b1;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized self-checking bench for seg7_scan against a frame-timing model.
// Honours SEG7_LEADING_ZERO_BLANK_EN the same way the design does.
module tb_seg7_scan;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [3:0] digit0_i, digit1_i, digit2_i, digit3_i;
  logic       digit0_en_i, digit1_en_i, digit2_en_i, digit3_en_i;
  logic [3:0] an_no;
  logic [6:0] seg_no;
  logic       dp_no;

  int total_cnt  = 0;
  int passed_cnt = 0;

  // Reference model: cycle count since reset release plus last captured frame
  int         m_n;
  logic [3:0] m_val [4];
  logic [3:0] m_en;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;

  seg7_scan #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .digit0_i    (digit0_i),
    .digit1_i    (digit1_i),
    .digit2_i    (digit2_i),
    .digit3_i    (digit3_i),
    .digit0_en_i (digit0_en_i),
    .digit1_en_i (digit1_en_i),
    .digit2_en_i (digit2_en_i),
    .digit3_en_i (digit3_en_i),
    .an_no       (an_no),
    .seg_no      (seg_no),
    .dp_no       (dp_no)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    string s;
    logic [6:0] g = '0;
    case (v)
      4'h0: s = "abcdef";  4'h1: s = "bc";      4'h2: s = "abdeg";   4'h3: s = "abcdg";
      4'h4: s = "bcfg";    4'h5: s = "acdfg";   4'h6: s = "acdefg";  4'h7: s = "abc";
      4'h8: s = "abcdefg"; 4'h9: s = "abcdfg";  4'hA: s = "abcefg";  4'hB: s = "cdefg";
      4'hC: s = "adef";    4'hD: s = "bcdeg";   4'hE: s = "adefg";   default: s = "aefg";
    endcase
    for (int i = 0; i < s.len(); i++) g[s[i] - 8'h61] = 1'b1;
    return g;
  endfunction

  function automatic logic [3:0] blank_mask();
    logic [3:0] b = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    for (int d = 3; d >= 1; d--) begin
      if (!m_en[d] || m_val[d] == 4'd0) b[d] = 1'b1;
      else break;
    end
`endif
    return b;
  endfunction

  task automatic set_digits(input logic [3:0] d3, d2, d1, d0, input logic [3:0] en);
    digit3_i = d3; digit2_i = d2; digit1_i = d1; digit0_i = d0;
    {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i} = en;
  endtask

  // Advance one clock; expected outputs describe the position before the edge
  task automatic tick();
    int p, slot, phase;
    logic [3:0] b;
    p = m_n;
    if (p % FRAME == 0) begin
      m_val[0] = digit0_i; m_val[1] = digit1_i; m_val[2] = digit2_i; m_val[3] = digit3_i;
      m_en = {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i};
    end
    slot  = (p / DIV) % 4;
    phase = p % DIV;
    b = blank_mask();
    if (m_en[slot] && phase >= BLANK && !b[slot]) begin
      exp_an  = ~(4'b0001 << slot);
      exp_seg = ~glyph(m_val[slot]);
    end else begin
      exp_an  = 4'b1111;
      exp_seg = 7'h7F;
    end
    @(posedge clk_i);
    #1;
    m_n++;
  endtask

  task automatic model_reset();
    m_n = 0;
    for (int i = 0; i < 4; i++) m_val[i] = '0;
    m_en = '0;
  endtask

  task automatic align_frame();
    while (m_n % FRAME != 0) tick();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    set_digits(4'd4, 4'd3, 4'd2, 4'd1, 4'b1111);
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    total_cnt++;
    if ({an_no, seg_no, dp_no} !== {4'b1111, 7'h7F, 1'b1})
      $display("[TB] FAIL reset_hold an=%b seg=%h dp=%b expected 1111 7f 1", an_no, seg_no, dp_no);
    else passed_cnt++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      total_cnt++;
      if ({an_no, seg_no} !== {exp_an, exp_seg})
        $display("[TB] FAIL reset_release n=%0d an=%b seg=%h expected an=%b seg=%h", m_n, an_no, seg_no, exp_an, exp_seg);
      else passed_cnt++;
    end
    while (m_n % FRAME != 12) tick();
    #2;
    rst_ni = 1'b0;
    #1;
    total_cnt++;
    if (an_no !== 4'b1111)
      $display("[TB] FAIL reset_async_an got=%b expected=1111", an_no);
    else passed_cnt++;
    total_cnt++;
    if (seg_no !== 7'h7F)
      $display("[TB] FAIL reset_async_seg got=%h expected=7f", seg_no);
    else passed_cnt++;
    total_cnt++;
    if (dp_no !== 1'b1)
      $display("[TB] FAIL reset_async_dp got=%b expected=1", dp_no);
    else passed_cnt++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if ({an_no, seg_no} !== {exp_an, exp_seg})
        $display("[TB] FAIL reset_restart n=%0d an=%b seg=%h expected an=%b seg=%h", m_n, an_no, seg_no, exp_an, exp_seg);
      else passed_cnt++;
    end
  endtask

  task automatic test_scan_order();
    logic [3:0] order [$];
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'b1111);
    align_frame();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      total_cnt++;
      if ({an_no, seg_no, dp_no} !== {exp_an, exp_seg, 1'b1})
        $display("[TB] FAIL scan n=%0d an=%b seg=%h expected an=%b seg=%h", m_n, an_no, seg_no, exp_an, exp_seg);
      else passed_cnt++;
      if (an_no != 4'b1111 && (order.size() == 0 || order[$] != an_no)) order.push_back(an_no);
    end
    total_cnt++;
    if (order.size() != 8 || order[0] !== 4'b1110 || order[1] !== 4'b1101 ||
        order[2] !== 4'b1011 || order[3] !== 4'b0111)
      $display("[TB] FAIL scan_sequence slots_seen=%0d expected 8 in order 1110,1101,1011,0111", order.size());
    else passed_cnt++;
  endtask

  task automatic test_snapshot();
    set_digits(4'd9, 4'd8, 4'd7, 4'd5, 4'b1111);
    align_frame();
    repeat (FRAME) tick();
    for (int i = 0; i < 2 * DIV; i++) begin
      tick();
      total_cnt++;
      if ({an_no, seg_no} !== {exp_an, exp_seg})
        $display("[TB] FAIL snapshot_before n=%0d an=%b seg=%h expected an=%b seg=%h", m_n, an_no, seg_no, exp_an, exp_seg);
      else passed_cnt++;
    end
    digit0_i = 4'd6;
    for (int i = 0; i < 3 * FRAME / 2; i++) begin
      tick();
      total_cnt++;
      if ({an_no, seg_no} !== {exp_an, exp_seg})
        $display("[TB] FAIL snapshot_after n=%0d an=%b seg=%h expected an=%b seg=%h", m_n, an_no, seg_no, exp_an, exp_seg);
      else passed_cnt++;
      if (an_no == 4'b1110) begin
        total_cnt++;
        if (seg_no !== ~glyph(4'd6))
          $display("[TB] FAIL snapshot_new_digit seg=%h expected=%h", seg_no, ~glyph(4'd6));
        else passed_cnt++;
      end
    end
  endtask

  task automatic test_enable();
    logic saw_an2 = 1'b0;
    set_digits(4'd3, 4'd8, 4'd1, 4'd0, 4'b1011);
    align_frame();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      total_cnt++;
      if ({an_no, seg_no} !== {exp_an, exp_seg})
        $display("[TB] FAIL enable n=%0d an=%b seg=%h expected an=%b seg=%h", m_n, an_no, seg_no, exp_an, exp_seg);
      else passed_cnt++;
      if (m_n > FRAME && an_no[2] == 1'b0) saw_an2 = 1'b1;
    end
    total_cnt++;
    if (saw_an2 !== 1'b0)
      $display("[TB] FAIL enable_an2 got=lit expected=dark");
    else passed_cnt++;
  endtask

  task automatic test_zero_digits(input logic [3:0] d3, d2, d1, d0, input logic [3:0] lit_req);
    logic [3:0] lit = '0;
    set_digits(d3, d2, d1, d0, 4'b1111);
    align_frame();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      total_cnt++;
      if ({an_no, seg_no} !== {exp_an, exp_seg})
        $display("[TB] FAIL zeros n=%0d an=%b seg=%h expected an=%b seg=%h", m_n, an_no, seg_no, exp_an, exp_seg);
      else passed_cnt++;
      if (m_n > FRAME) lit = lit | ~an_no;
    end
    total_cnt++;
    if (lit !== lit_req)
      $display("[TB] FAIL zeros_lit_mask got=%b expected=%b", lit, lit_req);
    else passed_cnt++;
  endtask

  task automatic test_hex_glyphs();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_digits(4'hD, 4'hC, 4'hB, 4'hA, 4'b1111);
      else        set_digits(4'hA, 4'hB, 4'hF, 4'hE, 4'b1111);
      align_frame();
      for (int i = 0; i < 2 * FRAME; i++) begin
        tick();
        total_cnt++;
        if ({an_no, seg_no} !== {exp_an, exp_seg})
          $display("[TB] FAIL hex n=%0d an=%b seg=%h expected an=%b seg=%h", m_n, an_no, seg_no, exp_an, exp_seg);
        else passed_cnt++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12 * FRAME; i++) begin
      if ($urandom_range(0, 9) == 0)
        set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   4'($urandom) | 4'($urandom));
      tick();
      total_cnt++;
      if ({an_no, seg_no, dp_no} !== {exp_an, exp_seg, 1'b1})
        $display("[TB] FAIL random n=%0d an=%b seg=%h expected an=%b seg=%h", m_n, an_no, seg_no, exp_an, exp_seg);
      else passed_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_snapshot();
    test_enable();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    test_zero_digits(4'd0, 4'd0, 4'd7, 4'd0, 4'b0011);
    test_zero_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'b0001);
`else
    test_zero_digits(4'd0, 4'd0, 4'd7, 4'd0, 4'b1111);
    test_zero_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'b1111);
`endif
    test_hex_glyphs();
    test_random();
    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule
